multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32 datapath: walks FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/ctrl_op_class.sv | 22 ++
 rtl/multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control-path definitions: supported opcodes, ALU function codes,
// sequencer state encoding and the opcode classification record.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_OP_ADD = 4'b0000;
  localparam logic [3:0] ALU_OP_RFN = 4'b0010;
  localparam logic [3:0] ALU_OP_CMP = 4'b0111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } ctrl_state_e;

  typedef struct packed {
    logic is_r;
    logic is_ld;
    logic is_st;
    logic is_br;
    logic is_ill;
  } op_class_t;

endpackage

// File: rtl/ctrl_op_class.sv
// Combinational opcode classifier shared by the single- and multi-cycle
// control paths; exactly one class bit is set for any opcode.
module ctrl_op_class
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  // Anything outside the four supported major opcodes is illegal.
  always_comb begin
    op_class = 5'b00000;
    case (opcode)
      OP_R:      op_class.is_r   = 1'b1;
      OP_LOAD:   op_class.is_ld  = 1'b1;
      OP_STORE:  op_class.is_st  = 1'b1;
      OP_BRANCH: op_class.is_br  = 1'b1;
      default:   op_class.is_ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout abort.
// Optional retired-instruction counter enabled by defining MCTRL_PERF_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
`ifdef MCTRL_PERF_EN
  ,
  parameter int PERF_W  = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_wr,
  output logic        ir_wr,
  output logic        mem_req,
  output logic        branch,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_to_regs,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        reg_wr,
  output logic        illegal,
  output logic        bus_err
`ifdef MCTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] retired
`endif
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  ctrl_state_e      state_r, state_s;
  logic [6:0]       op_q_r;
  logic [6:0]       cls_src_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             run_r;
  logic             tmo_s;
  op_class_t        cls_s;

  // DECODE classifies the live IR opcode; later states use the captured copy.
  assign cls_src_s = (state_r == DECODE) ? opcode : op_q_r;
  assign tmo_s     = (cnt_r == TMO_LAST);

  ctrl_op_class u_op_class (
    .opcode   (cls_src_s),
    .op_class (cls_s)
  );

  // State, captured opcode, wait counter and the post-reset run flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
      op_q_r  <= 7'b0000000;
      cnt_r   <= '0;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      run_r   <= 1'b1;
      if (run_r && (state_r == DECODE)) begin
        op_q_r <= opcode;
      end else begin
        op_q_r <= op_q_r;
      end
    end
  end

  // Next state and strobe decode; run_r keeps every output low in the first cycle after reset.
  always_comb begin
    state_s     = state_r;
    cnt_s       = '0;
    pc_wr       = 1'b0;
    ir_wr       = 1'b0;
    mem_req     = 1'b0;
    branch      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_to_regs = 1'b0;
    alu_op      = ALU_OP_ADD;
    alu_src     = 1'b0;
    reg_wr      = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;
    if (run_r) begin
      case (state_r)
        FETCH: begin
          mem_req = 1'b1;
          mem_rd  = 1'b1;
          if (mem_ready) begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_s = DECODE;
          end else if (tmo_s) begin
            bus_err = 1'b1;
            state_s = FETCH;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        DECODE: begin
          if (cls_s.is_ill) begin
            illegal = 1'b1;
            state_s = FETCH;
          end else begin
            state_s = EXEC;
          end
        end
        EXEC: begin
          if (cls_s.is_r) begin
            alu_op  = ALU_OP_RFN;
            state_s = WB;
          end else if (cls_s.is_ld || cls_s.is_st) begin
            alu_op  = ALU_OP_ADD;
            alu_src = 1'b1;
            state_s = MEM;
          end else if (cls_s.is_br) begin
            branch  = 1'b1;
            alu_op  = ALU_OP_CMP;
            state_s = FETCH;
          end else begin
            state_s = FETCH;
          end
        end
        MEM: begin
          mem_req = 1'b1;
          alu_src = 1'b1;
          mem_rd  = cls_s.is_ld;
          mem_wr  = cls_s.is_st;
          if (mem_ready) begin
            if (cls_s.is_ld) begin
              state_s = WB;
            end else begin
              state_s = FETCH;
            end
          end else if (tmo_s) begin
            bus_err = 1'b1;
            state_s = FETCH;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        WB: begin
          reg_wr      = 1'b1;
          mem_to_regs = cls_s.is_ld;
          state_s     = FETCH;
        end
        default: begin
          state_s = FETCH;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

`ifdef MCTRL_PERF_EN
  logic retire_s;

  assign retire_s = run_r && (((state_r == EXEC) && cls_s.is_br) ||
                              ((state_r == MEM) && cls_s.is_st && mem_ready) ||
                              (state_r == WB));

  // Retired-instruction count, wrapping at 2^PERF_W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (retire_s) begin
      retired <= retired + PERF_W'(1);
    end else begin
      retired <= retired;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations from a
// cycle-budget model, compared by a monitor at each instruction end.
module tb_multicycle_ctrl;

  localparam int T = 16;
  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam int K_WB = 1, K_ST = 2, K_BR = 3, K_ILL = 4, K_BERR = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = 7'b0000000;
  logic mem_ready = 1'b0;
  logic pc_wr, ir_wr, mem_req, branch, mem_rd, mem_wr, mem_to_regs;
  logic alu_src, reg_wr, illegal, bus_err;
  logic [3:0] alu_op;
`ifdef MCTRL_PERF_EN
  logic [31:0] retired;
`endif

  typedef struct {
    int kind; int cyc; int n_req; int n_rd; int n_wr; int n_src; int n_ir;
    int n_pc; int n_br; int n_rw; int n_ill; int n_berr; int m2r; int alu;
  } rec_t;
  typedef struct { bit is_fetch; logic [6:0] op; int w; } req_t;

  rec_t exp_q[$];
  req_t req_q[$];
  int n_cmp = 0, n_fail = 0, n_ret_exp = 0, n_instr = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .mem_req(mem_req), .branch(branch),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_to_regs(mem_to_regs),
    .alu_op(alu_op), .alu_src(alu_src), .reg_wr(reg_wr),
    .illegal(illegal), .bus_err(bus_err)
`ifdef MCTRL_PERF_EN
    , .retired(retired)
`endif
  );

  // Expected strobe counts and length of one instruction, from the cycle budget of each phase.
  function automatic rec_t model(logic [6:0] op, int wf, int wm);
    rec_t e = '{default: 0};
    int f, m;
    f = (wf >= T) ? T : wf + 1;
    m = (wm >= T) ? T : wm + 1;
    e.n_req = f;
    e.n_rd  = f;
    if (wf >= T) begin
      e.kind = K_BERR; e.n_berr = 1; e.cyc = f;
      return e;
    end
    e.n_ir = 1; e.n_pc = 1;
    if (op == R_OP) begin
      e.kind = K_WB; e.cyc = f + 3; e.alu = 2; e.n_rw = 1;
    end else if (op == BR_OP) begin
      e.kind = K_BR; e.cyc = f + 2; e.alu = 7; e.n_br = 1;
    end else if (op == LD_OP || op == ST_OP) begin
      e.n_req += m;
      e.n_src = 1 + m;
      if (op == LD_OP) e.n_rd += m;
      else e.n_wr = m;
      if (wm >= T) begin
        e.kind = K_BERR; e.n_berr = 1; e.cyc = f + 2 + m;
      end else if (op == LD_OP) begin
        e.kind = K_WB; e.cyc = f + 3 + m; e.m2r = 1; e.n_rw = 1;
      end else begin
        e.kind = K_ST; e.cyc = f + 2 + m;
      end
    end else begin
      e.kind = K_ILL; e.cyc = f + 1; e.n_ill = 1;
    end
    return e;
  endfunction

  function automatic bit rec_eq(rec_t a, rec_t b);
    return a.kind == b.kind && a.cyc == b.cyc && a.n_req == b.n_req && a.n_rd == b.n_rd &&
           a.n_wr == b.n_wr && a.n_src == b.n_src && a.n_ir == b.n_ir && a.n_pc == b.n_pc &&
           a.n_br == b.n_br && a.n_rw == b.n_rw && a.n_ill == b.n_ill &&
           a.n_berr == b.n_berr && a.m2r == b.m2r && a.alu == b.alu;
  endfunction

  function automatic string fmt(rec_t r);
    return $sformatf("kind=%0d cyc=%0d req=%0d rd=%0d wr=%0d src=%0d ir=%0d pc=%0d br=%0d rw=%0d ill=%0d berr=%0d m2r=%0d alu=%0d",
                     r.kind, r.cyc, r.n_req, r.n_rd, r.n_wr, r.n_src, r.n_ir, r.n_pc,
                     r.n_br, r.n_rw, r.n_ill, r.n_berr, r.m2r, r.alu);
  endfunction

  function automatic logic [14:0] outs();
    return {pc_wr, ir_wr, mem_req, branch, mem_rd, mem_wr, mem_to_regs, alu_op,
            alu_src, reg_wr, illegal, bus_err};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_instr(logic [6:0] op, int wf, int wm);
    rec_t e;
    req_q.push_back('{1'b1, op, wf});
    if (wf < T && (op == LD_OP || op == ST_OP)) req_q.push_back('{1'b0, 7'b0000000, wm});
    e = model(op, wf, wm);
    exp_q.push_back(e);
    if (e.kind == K_WB || e.kind == K_ST || e.kind == K_BR) n_ret_exp++;
  endtask

  task automatic drain(int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk); #3;
      c++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: %0d instructions outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 9);
    if (r < 5) return 0;
    if (r < 8) return $urandom_range(1, 3);
    if (r == 8) return T - 1;
    return T + $urandom_range(0, 2);
  endfunction

  // Memory responder: answers each request after its planned wait, toggles ready and opcode when idle.
  initial begin : responder
    int k, w;
    bit active, cur_fetch, dec_next;
    req_t e;
    active = 1'b0; cur_fetch = 1'b0; dec_next = 1'b0; k = 0; w = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0; dec_next = 1'b0; mem_ready = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1'b1; k = 0;
          if (req_q.size() != 0) begin
            e = req_q.pop_front();
            w = e.w; cur_fetch = e.is_fetch;
            if (e.is_fetch) opcode = e.op;
          end else begin
            w = 1000; cur_fetch = 1'b0;
          end
        end
        mem_ready = (k == w);
        if (k == w && cur_fetch) dec_next = 1'b1;
        if (k == w || k == T - 1) active = 1'b0;
        else k++;
      end else begin
        active = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        if (dec_next) dec_next = 1'b0;
        else opcode = 7'($urandom);
      end
    end
  end

  // Monitor: accumulates strobes per instruction and compares at each instruction end.
  initial begin : monitor
    rec_t cur, e;
    bit started;
    int k;
    cur = '{default: 0};
    started = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        cur = '{default: 0};
        started = 1'b0;
      end else begin
        if (mem_req) started = 1'b1;
        if (started) begin
          cur.cyc++;
          cur.n_req += int'(mem_req);  cur.n_rd  += int'(mem_rd);
          cur.n_wr  += int'(mem_wr);   cur.n_src += int'(alu_src);
          cur.n_ir  += int'(ir_wr);    cur.n_pc  += int'(pc_wr);
          cur.n_br  += int'(branch);   cur.n_rw  += int'(reg_wr);
          cur.n_ill += int'(illegal);  cur.n_berr += int'(bus_err);
          cur.m2r   |= int'(mem_to_regs);
          cur.alu   |= int'(alu_op);
          k = illegal ? K_ILL : bus_err ? K_BERR : branch ? K_BR : reg_wr ? K_WB :
              (mem_wr && mem_ready) ? K_ST : 0;
          if (k != 0) begin
            cur.kind = k;
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_end: got %s, expected no instruction", fmt(cur));
            end else begin
              e = exp_q.pop_front();
              if (!rec_eq(cur, e)) begin
                n_fail++;
                $display("FAIL instr%0d: got %s; expected %s", n_instr, fmt(cur), fmt(e));
              end
            end
            n_instr++;
            cur = '{default: 0};
          end
        end
      end
    end
  end

  initial begin : main
    bit found;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'd0);
`ifdef MCTRL_PERF_EN
    check("reset_retired", retired, 32'd0);
`endif
    push_instr(R_OP, 0, 0);
    push_instr(LD_OP, 0, 2);
    push_instr(ST_OP, 0, 0);
    push_instr(BR_OP, 0, 0);
    push_instr(7'b1111111, 0, 0);
    push_instr(R_OP, T, 0);
    push_instr(R_OP, T - 1, 0);
    push_instr(LD_OP, 0, T);
    push_instr(ST_OP, 1, T - 1);
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [6:0] op;
      r = $urandom_range(0, 9);
      if (r < 2) op = R_OP;
      else if (r < 4) op = LD_OP;
      else if (r < 6) op = ST_OP;
      else if (r < 8) op = BR_OP;
      else begin
        op = 7'($urandom);
        if (op == R_OP || op == LD_OP || op == ST_OP || op == BR_OP) op = 7'b1111111;
      end
      push_instr(op, pick_wait(), pick_wait());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drain(5000);
`ifdef MCTRL_PERF_EN
    check("retired_total", retired, 32'(n_ret_exp));
`endif

    // Reset in the middle of a stalled store.
    req_q.push_back('{1'b1, ST_OP, 0});
    req_q.push_back('{1'b0, 7'b0000000, T + 4});
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk); #3;
      if (mem_wr) found = 1'b1;
    end
    check("mid_mem_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_mid_mem_outs", 32'(outs()), 32'd0);
`ifdef MCTRL_PERF_EN
    check("reset_mid_mem_retired", retired, 32'd0);
`endif
    req_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_instr(R_OP, 0, 0);
    push_instr(BR_OP, 0, 0);
    push_instr(ST_OP, 0, 0);
    rst_n = 1'b1;
    drain(500);
`ifdef MCTRL_PERF_EN
    check("retired_after_3", retired, 32'd3);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
